multicycle_mips_core: RTL and testbench
=======================================

Name: multicycle_mips_core

Overview:
- Multi-cycle successor to the single-cycle MIPS datapath: one shared memory port, FSM-sequenced datapath, parametrised reset vector and address width.
- Memory port uses a variable-latency req/ready handshake, so the core runs against real SRAM/bus models.
- Sits under the top-level SoC wrapper, beside a unified instruction/data memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, mem_addr width; {PC, ALUOut}[ADDR_W-1:0] is driven, 2 ≤ ADDR_W ≤ 32.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_ready  in  1  transfer completes on the edge where mem_req && mem_ready.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- retire  out  1  one-cycle pulse when an instruction commits.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- halted  out  1  core stopped (only with optional feature).

Behaviour:
- ISA: add, sub, and, or, slt (R-type); lw, sw, beq, addi, j. Sign-extended immediates. Branch target = PC+4 + (simm<<2). Jump target = {PC+4[31:28], idx, 2'b00}. All arithmetic is 32-bit wrap; no overflow traps. $0 reads 0; writes to $0 are discarded.
- Reset (reset=0 at an edge): state←IDLE, PC←RESET_PC, all 31 GPRs←0, IR/A/B/ALUOut/MDR←0, instr_count←0. While in IDLE: mem_req=0, mem_we=0, retire=0, halted=0.
- Reset wins over every other event. An outstanding memory request is abandoned with no register or PC update; mem_req is 0 from the next cycle.
- States and transitions:
  - IDLE → FETCH unconditionally.
  - FETCH: mem_req=1, mem_we=0, addr=PC. Hold until ready. On ready: IR←rdata, PC←PC+4, → DECODE.
  - DECODE: A←GPR[rs], B←GPR[rt], ALUOut←branch target. j: PC←jump target, retire, → FETCH. Otherwise → EXEC.
  - EXEC:
    - R-type: ALUOut←A op B, → WB.
    - lw/sw/addi: ALUOut←A+simm. lw/sw → MEM; addi → WB.
    - beq: if A==B then PC←ALUOut. Retire, → FETCH.
  - MEM: mem_req=1, addr=ALUOut, mem_we=(sw), wdata=B. Hold until ready. sw: retire, → FETCH. lw: MDR←rdata, → WB.
  - WB: GPR[rd] (R-type) or GPR[rt] (lw/addi) ← ALUOut/MDR. Retire, → FETCH.
- Latency with zero-wait memory (ready tied 1), in cycles: j 2, beq 3, sw 4, R-type 4, addi 4, lw 5. Each memory wait cycle adds 1.
- Handshake: mem_addr, mem_we and mem_wdata stay stable while mem_req=1 && !mem_ready. mem_req never drops before completion except on reset. mem_ready while mem_req=0 is ignored.
- retire: exactly one pulse per committed instruction, asserted in the committing cycle. instr_count increments on that same edge.
- Unaligned addresses: low 2 bits are forced to 0 on mem_addr.
- Unknown opcode/funct: executes as NOP (retires from DECODE, 2 cycles) unless the optional feature is compiled in.

Optional Feature:
- Macro: MULTICYCLE_MIPS_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode/funct in DECODE → state HALT. In HALT: halted=1, mem_req=0, no retire, PC frozen at the illegal instruction's address + 4. Only reset leaves HALT.
- Undefined: HALT state does not exist, halted is tied 0, and unknown opcodes are NOPs.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode and funct localparams;
  - the FSM state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - 3-bit ALU control codes (ADD, SUB, AND, OR, SLT).
- Sub-module mips_mc_regfile: 32×32, 2 async read ports, 1 sync write port, $0 hardwired, synchronous active-low clear.
- ALU and FSM stay in the top module.

Test Plan:
- Reset with RESET_PC=32'h100, ready=1: mem_req=0 during reset and IDLE. First FETCH addr=0x100. instr_count=0.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 → $3=2, $4=1. 4 retires over 16 cycles after IDLE.
- sw $1,8($0) then lw $5,8($0), with ready delayed 3 cycles per request → mem_addr/wdata held stable while waiting, write of 5 at addr 8, $5=5. Total cycles = 4+5+4×3.
- beq $1,$1,+2 at PC=0x10 → next FETCH at 0x1C. beq not taken → 0x14. j 0x40 → FETCH at 0x100.
- Reset asserted mid-MEM with ready=0 → no write observed, mem_req=0 next cycle, PC=RESET_PC, GPRs cleared.
- Opcode 6'h3F with MULTICYCLE_MIPS_ILLEGAL_TRAP_EN → halted=1 after DECODE, no further mem_req. Without the macro → NOP, retire pulses, next FETCH at PC+4.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs,
// FSM state encoding, ALU control codes and small decode helpers.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic logic [31:0] alu_f(input alu_op_t op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            ALU_SUB: alu_f = a - b;
            ALU_AND: alu_f = a & b;
            ALU_OR:  alu_f = a | b;
            ALU_SLT: alu_f = {31'b0, $signed(a) < $signed(b)};
            default: alu_f = a + b;
        endcase
    endfunction

    function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  funct_to_alu = ALU_SUB;
            FN_AND:  funct_to_alu = ALU_AND;
            FN_OR:   funct_to_alu = ALU_OR;
            FN_SLT:  funct_to_alu = ALU_SLT;
            default: funct_to_alu = ALU_ADD;
        endcase
    endfunction

    // True for every opcode/funct pair the core implements.
    function automatic logic is_legal(input logic [31:0] ir);
        case (ir[31:26])
            OP_RTYPE: is_legal = (ir[5:0] == FN_ADD) || (ir[5:0] == FN_SUB) ||
                                 (ir[5:0] == FN_AND) || (ir[5:0] == FN_OR)  ||
                                 (ir[5:0] == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// $0 hardwired to zero, synchronous active-low clear.
module mips_mc_regfile (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_raddr0,
    input  logic [4:0]  i_raddr1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);
    logic [31:0] r_regs [32];

    // Clear on reset, otherwise write any register except $0.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = (i_raddr0 == 5'd0) ? 32'd0 : r_regs[i_raddr0];
    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];

endmodule

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS core with a single shared req/ready memory port.
// Optional illegal-instruction trap: define MULTICYCLE_MIPS_ILLEGAL_TRAP_EN.
module multicycle_mips_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_retire,
    output logic [CNT_W-1:0]  o_instr_count,
    output logic              o_halted
);
    state_t           r_state;
    logic [31:0]      r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [CNT_W-1:0] r_instr_count;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_simm, w_rs_data, w_rt_data, w_alu_res, w_branch_tgt, w_addr_full;
    logic        w_legal, w_retire, w_wb_en;
    logic [4:0]  w_wb_addr;
    logic [31:0] w_wb_data;

    assign w_op         = r_ir[31:26];
    assign w_rs         = r_ir[25:21];
    assign w_rt         = r_ir[20:16];
    assign w_rd         = r_ir[15:11];
    assign w_funct      = r_ir[5:0];
    assign w_simm       = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_legal      = is_legal(r_ir);
    assign w_branch_tgt = r_pc + {w_simm[29:0], 2'b00};

    assign w_wb_en   = (r_state == S_WB);
    assign w_wb_addr = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_aluout;

    mips_mc_regfile u_rf (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_raddr0 (w_rs),
        .i_raddr1 (w_rt),
        .o_rdata0 (w_rs_data),
        .o_rdata1 (w_rt_data),
        .i_we     (w_wb_en),
        .i_waddr  (w_wb_addr),
        .i_wdata  (w_wb_data)
    );

    // EXEC-stage ALU: R-type uses funct, everything else adds the immediate.
    always_comb begin
        w_alu_res = alu_f(ALU_ADD, r_a, w_simm);
        if (w_op == OP_RTYPE) w_alu_res = alu_f(funct_to_alu(w_funct), r_a, r_b);
    end

    // Commit strobe, asserted in the cycle whose closing edge retires.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
`ifdef MULTICYCLE_MIPS_ILLEGAL_TRAP_EN
            S_DECODE: w_retire = (w_op == OP_J);
`else
            S_DECODE: w_retire = (w_op == OP_J) || !w_legal;
`endif
            S_EXEC:   w_retire = (w_op == OP_BEQ);
            S_MEM:    w_retire = (w_op == OP_SW) && i_mem_ready;
            S_WB:     w_retire = 1'b1;
            default:  w_retire = 1'b0;
        endcase
    end

    // Memory port is decoded straight from state registers, so it holds steady while waiting.
    assign w_addr_full   = (r_state == S_FETCH) ? r_pc : r_aluout;
    assign o_mem_req     = (r_state == S_FETCH) || (r_state == S_MEM);
    assign o_mem_we      = (r_state == S_MEM) && (w_op == OP_SW);
    assign o_mem_addr    = w_addr_full[ADDR_W-1:0] & ~ADDR_W'(3);
    assign o_mem_wdata   = r_b;
    assign o_retire      = w_retire;
    assign o_instr_count = r_instr_count;
`ifdef MULTICYCLE_MIPS_ILLEGAL_TRAP_EN
    assign o_halted      = (r_state == S_HALT);
`else
    assign o_halted      = 1'b0;
`endif

    // Main sequencer: state, PC, datapath latches and retire counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_aluout      <= '0;
            r_mdr         <= '0;
            r_instr_count <= '0;
        end else begin
            if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: if (i_mem_ready) begin
                    r_ir    <= i_mem_rdata;
                    r_pc    <= r_pc + 32'd4;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_a      <= w_rs_data;
                    r_b      <= w_rt_data;
                    r_aluout <= w_branch_tgt;
                    if (w_op == OP_J) begin
                        r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        r_state <= S_FETCH;
                    end else if (!w_legal) begin
`ifdef MULTICYCLE_MIPS_ILLEGAL_TRAP_EN
                        r_state <= S_HALT;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_BEQ) begin
                        if (r_a == r_b) r_pc <= r_aluout;
                        r_state <= S_FETCH;
                    end else begin
                        r_aluout <= w_alu_res;
                        r_state  <= ((w_op == OP_LW) || (w_op == OP_SW)) ? S_MEM : S_WB;
                    end
                end
                S_MEM: if (i_mem_ready) begin
                    if (w_op == OP_SW) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_mdr   <= i_mem_rdata;
                        r_state <= S_WB;
                    end
                end
                S_WB: r_state <= S_FETCH;
`ifdef MULTICYCLE_MIPS_ILLEGAL_TRAP_EN
                S_HALT: r_state <= S_HALT;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed self-checking bench for multicycle_mips_core with a
// variable-latency unified memory model.
module tb_multicycle_mips_core;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b0, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, instr_count;

    int n_chk = 0, n_fail = 0;

    multicycle_mips_core #(.RESET_PC(RST_PC), .ADDR_W(32), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(rst_n), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready),
        .i_mem_rdata(mem_rdata), .o_retire(retire), .o_instr_count(instr_count),
        .o_halted(halted)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } xfer_t;
    logic [31:0] mem [1024];
    xfer_t rd_log[$], wr_log[$];
    int  wait_cfg = 0, wcnt = 0, cyc = 0, unstable = 0;
    bit  block_wr = 0, held = 0;
    logic [31:0] h_addr, h_wdata;
    logic h_we;

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (mem_req) begin
            if (held && (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_we !== h_we)) unstable++;
            if (wcnt >= wait_cfg && !(block_wr && mem_we)) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                wcnt = 0;
                held = 0;
                if (mem_we) begin
                    mem[mem_addr[11:2]] = mem_wdata;
                    wr_log.push_back(xfer_t'{mem_addr, mem_wdata, cyc});
                end else begin
                    rd_log.push_back(xfer_t'{mem_addr, mem_rdata, cyc});
                end
            end else begin
                mem_ready = 1'b0;
                wcnt++;
                held = 1;
                h_addr = mem_addr; h_wdata = mem_wdata; h_we = mem_we;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
            held = 0;
        end
    end

    // ---------------- encoders / helpers ----------------
    function automatic logic [31:0] e_r(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] e_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] e_j(int idx);
        return {6'h02, 26'(idx)};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask
    // Hold reset for a few edges, then release it during the IDLE cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rd_log.delete();
        wr_log.delete();
        unstable = 0;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wait_cfg = 0; block_wr = 0;
        clear_mem();
        put(32'h100, e_j(32'h40));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        n_chk++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        n_chk++; if (retire !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_flags retire=%b halted=%b exp=0/0", retire, halted); end
        rst_n = 1'b1;
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", mem_req); end
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL first_fetch req=%b we=%b addr=%h exp=1/0/00000100", mem_req, mem_we, mem_addr); end
        n_chk++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL fetch_count got=%0d exp=0", instr_count); end
    endtask

    task automatic test_alu();
        logic [31:0] exp_a [7] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218};
        logic [31:0] exp_d [7] = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0};
        int rets = 0, c4 = -1;
        wait_cfg = 0; block_wr = 0;
        clear_mem();
        put(32'h100, e_i(6'h08, 0, 1, 5));
        put(32'h104, e_i(6'h08, 0, 2, -3));
        put(32'h108, e_r(1, 2, 3, 6'h20));
        put(32'h10C, e_r(2, 1, 4, 6'h2A));
        put(32'h110, e_r(1, 2, 6, 6'h22));
        put(32'h114, e_r(1, 2, 7, 6'h24));
        put(32'h118, e_r(1, 2, 8, 6'h25));
        put(32'h11C, e_r(1, 2, 9, 6'h2A));
        put(32'h120, e_i(6'h08, 0, 0, 7));
        put(32'h124, e_i(6'h2B, 0, 3, 32'h200));
        put(32'h128, e_i(6'h2B, 0, 4, 32'h204));
        put(32'h12C, e_i(6'h2B, 0, 6, 32'h208));
        put(32'h130, e_i(6'h2B, 0, 7, 32'h20C));
        put(32'h134, e_i(6'h2B, 0, 8, 32'h210));
        put(32'h138, e_i(6'h2B, 0, 9, 32'h214));
        put(32'h13C, e_i(6'h2B, 0, 0, 32'h218));
        put(32'h140, e_j(32'h50));
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (retire === 1'b1) begin rets++; if (rets == 4) c4 = c; end
            if (c == 17) begin
                n_chk++; if (instr_count !== 32'd4) begin n_fail++; $display("FAIL alu_count got=%0d exp=4", instr_count); end
            end
        end
        n_chk++; if (c4 !== 16) begin n_fail++; $display("FAIL alu_4th_retire_cycle got=%0d exp=16", c4); end
        repeat (80) @(negedge clk);
        n_chk++; if (wr_log.size() !== 7) begin n_fail++; $display("FAIL alu_store_count got=%0d exp=7", wr_log.size()); end
        else begin
            for (int i = 0; i < 7; i++) begin
                n_chk++; if (wr_log[i].addr !== exp_a[i] || wr_log[i].data !== exp_d[i]) begin
                    n_fail++; $display("FAIL alu_store%0d got=%h@%h exp=%h@%h", i, wr_log[i].data, wr_log[i].addr, exp_d[i], exp_a[i]); end
            end
        end
    endtask

    task automatic test_mem_wait();
        int rets = 0, r1 = -1, r3 = -1;
        wait_cfg = 3; block_wr = 0;
        clear_mem();
        put(32'h100, e_i(6'h08, 0, 1, 5));
        put(32'h104, e_i(6'h2B, 0, 1, 8));
        put(32'h108, e_i(6'h23, 0, 5, 8));
        put(32'h10C, e_i(6'h2B, 0, 5, 32'h2B));
        put(32'h110, e_j(32'h44));
        do_reset();
        for (int c = 1; c <= 100 && rets < 3; c++) begin
            @(negedge clk);
            if (retire === 1'b1) begin
                rets++;
                if (rets == 1) r1 = c;
                if (rets == 3) r3 = c;
            end
        end
        n_chk++; if (rets != 3 || (r3 - r1) != 21) begin
            n_fail++; $display("FAIL mem_sw_lw_cycles got=%0d retires=%0d exp=21", r3 - r1, rets); end
        repeat (60) @(negedge clk);
        n_chk++; if (unstable !== 0) begin n_fail++; $display("FAIL mem_hold_stable changes=%0d exp=0", unstable); end
        n_chk++; if (wr_log.size() < 2) begin n_fail++; $display("FAIL mem_store_count got=%0d exp=2", wr_log.size()); end
        else begin
            n_chk++; if (wr_log[0].addr !== 32'h8 || wr_log[0].data !== 32'd5) begin
                n_fail++; $display("FAIL mem_sw got=%h@%h exp=00000005@00000008", wr_log[0].data, wr_log[0].addr); end
            n_chk++; if (wr_log[1].addr !== 32'h28 || wr_log[1].data !== 32'd5) begin
                n_fail++; $display("FAIL mem_lw_unaligned got=%h@%h exp=00000005@00000028", wr_log[1].data, wr_log[1].addr); end
        end
        wait_cfg = 0;
    endtask

    task automatic test_branch();
        logic [31:0] exp_a [4] = '{32'h100, 32'h10, 32'h1C, 32'h100};
        logic [31:0] exp_b [5] = '{32'h100, 32'h104, 32'h10, 32'h14, 32'h100};
        wait_cfg = 0; block_wr = 0;
        // taken branch, preceded and followed by jumps
        clear_mem();
        put(32'h100, e_j(4));
        put(32'h10,  e_i(6'h04, 1, 1, 2));
        put(32'h1C,  e_j(32'h40));
        do_reset();
        repeat (30) @(negedge clk);
        n_chk++; if (rd_log.size() < 4) begin n_fail++; $display("FAIL br_taken_fetches got=%0d exp>=4", rd_log.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++; if (rd_log[i].addr !== exp_a[i]) begin
                    n_fail++; $display("FAIL br_taken_pc%0d got=%h exp=%h", i, rd_log[i].addr, exp_a[i]); end
            end
            n_chk++; if (rd_log[1].cyc - rd_log[0].cyc != 2) begin
                n_fail++; $display("FAIL j_latency got=%0d exp=2", rd_log[1].cyc - rd_log[0].cyc); end
            n_chk++; if (rd_log[2].cyc - rd_log[1].cyc != 3) begin
                n_fail++; $display("FAIL beq_latency got=%0d exp=3", rd_log[2].cyc - rd_log[1].cyc); end
        end
        // not-taken branch
        clear_mem();
        put(32'h100, e_i(6'h08, 0, 1, 1));
        put(32'h104, e_j(4));
        put(32'h10,  e_i(6'h04, 1, 0, 2));
        put(32'h14,  e_j(32'h40));
        do_reset();
        repeat (30) @(negedge clk);
        n_chk++; if (rd_log.size() < 5) begin n_fail++; $display("FAIL br_ntaken_fetches got=%0d exp>=5", rd_log.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++; if (rd_log[i].addr !== exp_b[i]) begin
                    n_fail++; $display("FAIL br_ntaken_pc%0d got=%h exp=%h", i, rd_log[i].addr, exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        bit seen = 0;
        wait_cfg = 0; block_wr = 1;
        clear_mem();
        put(32'h100, e_i(6'h08, 0, 1, 9));
        put(32'h104, e_i(6'h2B, 0, 1, 32'h40));
        put(32'h108, e_j(32'h42));
        do_reset();
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b1) seen = 1;
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL rst_mem_store_seen got=0 exp=1"); end
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'd9) begin
            n_fail++; $display("FAIL rst_mem_hold req=%b addr=%h wdata=%h exp=1/00000040/00000009", mem_req, mem_addr, mem_wdata); end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_drop got=%b exp=0", mem_req); end
        n_chk++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL rst_mem_count got=%0d exp=0", instr_count); end
        n_chk++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL rst_mem_no_write got=%0d exp=0", wr_log.size()); end
        block_wr = 0;
        put(32'h100, e_i(6'h2B, 0, 1, 32'h44));
        put(32'h104, e_j(32'h41));
        rd_log.delete(); wr_log.delete();
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
            n_fail++; $display("FAIL rst_mem_pc req=%b addr=%h exp=1/%h", mem_req, mem_addr, RST_PC); end
        repeat (20) @(negedge clk);
        n_chk++; if (wr_log.size() < 1) begin n_fail++; $display("FAIL rst_gpr_store got=%0d exp=1", wr_log.size()); end
        else begin
            n_chk++; if (wr_log[0].addr !== 32'h44 || wr_log[0].data !== 32'd0) begin
                n_fail++; $display("FAIL rst_gpr_clear got=%h@%h exp=00000000@00000044", wr_log[0].data, wr_log[0].addr); end
        end
    endtask

    task automatic test_illegal();
        int reqs = 0, rets = 0, halt_lo = 0;
        wait_cfg = 0; block_wr = 0;
        clear_mem();
        put(32'h100, e_i(6'h08, 0, 1, 7));
        put(32'h104, 32'hFC00_0000);
        put(32'h108, e_r(1, 1, 1, 6'h3F));
        put(32'h10C, e_i(6'h2B, 0, 1, 32'h50));
        put(32'h110, e_j(32'h44));
        do_reset();
        repeat (5) @(negedge clk);
        @(negedge clk);
`ifdef MULTICYCLE_MIPS_ILLEGAL_TRAP_EN
        n_chk++; if (retire !== 1'b0) begin n_fail++; $display("FAIL trap_no_retire got=%b exp=0", retire); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) reqs++;
            if (retire !== 1'b0) rets++;
            if (halted !== 1'b1) halt_lo++;
        end
        n_chk++; if (halt_lo != 0) begin n_fail++; $display("FAIL trap_halted low_cycles=%0d exp=0", halt_lo); end
        n_chk++; if (reqs != 0 || rets != 0) begin n_fail++; $display("FAIL trap_quiet reqs=%0d retires=%0d exp=0/0", reqs, rets); end
        n_chk++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL trap_count got=%0d exp=1", instr_count); end
`else
        n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL nop_retire got=%b exp=1", retire); end
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin
            n_fail++; $display("FAIL nop_next_fetch req=%b addr=%h exp=1/00000108", mem_req, mem_addr); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL nop_halted got=%b exp=0", halted); end
        repeat (20) @(negedge clk);
        n_chk++; if (wr_log.size() < 1) begin n_fail++; $display("FAIL nop_store got=%0d exp=1", wr_log.size()); end
        else begin
            n_chk++; if (wr_log[0].addr !== 32'h50 || wr_log[0].data !== 32'd7) begin
                n_fail++; $display("FAIL nop_funct_no_wb got=%h@%h exp=00000007@00000050", wr_log[0].data, wr_log[0].addr); end
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_reset_mid_mem();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
